// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic blocks: adder algorithm selectors and sequencer states.
// Purely declarative; no logic, no latency, no flow control.
// Imported by adder and seq_wide_adder.
package arith_pkg;

    localparam int ALG_RIPPLE = 0;
    localparam int ALG_CLA    = 1;

    typedef enum logic [1:0] {
        SWA_IDLE,
        SWA_RUN,
        SWA_DONE
    } swa_state_t;

endpackage

// File: rtl/adder.sv
// Combinational WIDTH-bit adder with carry-in; sum[WIDTH] is the carry-out.
// Latency: zero cycles (purely combinational).
// Backpressure: none; it has no flow control.
module adder
    import arith_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ALGORITHM = ALG_RIPPLE
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH:0]   sum
);

    generate
        if (ALGORITHM == ALG_CLA) begin : g_cla
            if (WIDTH % 4 != 0) begin : g_bad_width
                $error("adder: WIDTH must be a multiple of 4 for carry-look-ahead");
            end

            localparam int NG = WIDTH / 4;

            logic [WIDTH-1:0] g;
            logic [WIDTH-1:0] p;
            logic [NG:0]      gc;

            assign g     = a & b;
            assign p     = a ^ b;
            assign gc[0] = ci;

            // Full look-ahead inside each 4-bit group; group carries chain between groups.
            for (genvar k = 0; k < NG; k++) begin : g_grp
                logic [3:0] gg;
                logic [3:0] pp;
                logic [3:0] c;

                assign gg   = g[4*k +: 4];
                assign pp   = p[4*k +: 4];
                assign c[0] = gc[k];
                assign c[1] = gg[0] | (pp[0] & c[0]);
                assign c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[0]);
                assign c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                            | ((&pp[2:0]) & c[0]);
                assign gc[k+1] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                               | ((&pp[3:1]) & gg[0]) | ((&pp) & c[0]);
                assign sum[4*k +: 4] = pp ^ c;
            end

            assign sum[WIDTH] = gc[NG];
        end else begin : g_rca
            assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        end
    endgenerate

endmodule

// File: rtl/seq_wide_adder.sv
// Wide add sequenced over one CHUNK-bit slice adder, LSB chunk first (subtract with SEQ_WIDE_ADDER_SUB_EN).
// Latency: out_valid rises WIDTH/CHUNK edges after the accepting edge; one op in flight at a time.
// Backpressure: result held in DONE until out_ready; in_ready is low from accept until the result is taken.
module seq_wide_adder
    import arith_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int CHUNK     = 16,
    parameter int ALGORITHM = ALG_RIPPLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             cin,
`ifdef SEQ_WIDE_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("seq_wide_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    swa_state_t state;
    swa_state_t state_nxt;

    logic [IDXW-1:0]        idx;
    logic                   carry;
    logic [WIDTH-1:0]       a_q;
    logic [WIDTH-1:0]       b_q;
    logic [WIDTH-1:0]       res_q;
    logic [CHUNK-1:0]       slice_b;
    logic [CHUNK:0]         slice_sum;
    logic [WIDTH+CHUNK-1:0] res_cat;
    logic                   accept;
    logic                   carry_init;

`ifdef SEQ_WIDE_ADDER_SUB_EN
    logic sub_q;

    // a - b - cin == a + ~b + ~cin
    assign slice_b    = sub_q ? ~b_q[CHUNK-1:0] : b_q[CHUNK-1:0];
    assign carry_init = cin ^ in_sub;
`else
    assign slice_b    = b_q[CHUNK-1:0];
    assign carry_init = cin;
`endif

    adder #(
        .WIDTH     (CHUNK),
        .ALGORITHM (ALGORITHM)
    ) u_slice (
        .a   (a_q[CHUNK-1:0]),
        .b   (slice_b),
        .ci  (carry),
        .sum (slice_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SWA_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            SWA_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SWA_RUN;
                end
            end
            SWA_RUN: begin
                busy = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = SWA_DONE;
                end
            end
            SWA_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = SWA_IDLE;
                end
            end
            default: begin
                state_nxt = SWA_IDLE;
            end
        endcase
    end

    assign accept = in_valid && in_ready;

    // New chunk enters at the top; after NCHUNK steps chunk 0 has reached the LSBs.
    assign res_cat = {slice_sum[CHUNK-1:0], res_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
`ifdef SEQ_WIDE_ADDER_SUB_EN
            sub_q <= 1'b0;
`endif
        end else if (accept) begin
            idx   <= '0;
            carry <= carry_init;
            a_q   <= in0;
            b_q   <= in1;
`ifdef SEQ_WIDE_ADDER_SUB_EN
            sub_q <= in_sub;
`endif
        end else if (state == SWA_RUN) begin
            a_q   <= a_q >> CHUNK;
            b_q   <= b_q >> CHUNK;
            res_q <= res_cat[WIDTH+CHUNK-1:CHUNK];
            carry <= slice_sum[CHUNK];
            idx   <= (idx == LAST_IDX) ? '0 : idx + IDXW'(1);
        end
    end

    assign out_sum = {carry, res_q};

endmodule

// File: tb/tb_seq_wide_adder.sv
// Directed bench: two 32/8 instances (ripple and look-ahead) in lockstep plus an 8/8 single-chunk instance.
// Subtract vectors are exercised when SEQ_WIDE_ADDER_SUB_EN is defined.
module tb_seq_wide_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        cin;
    logic        in_sub;
    logic        out_ready;

    logic        in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1;
    logic [32:0] out_sum0, out_sum1;

    logic        n_in_valid, n_cin, n_in_sub, n_out_ready;
    logic [7:0]  n_in0, n_in1;
    logic        n_in_ready, n_out_valid, n_busy;
    logic [8:0]  n_out_sum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_wide_adder #(.WIDTH(32), .CHUNK(8), .ALGORITHM(0)) u_rca (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in0(in0), .in1(in1), .cin(cin),
`ifdef SEQ_WIDE_ADDER_SUB_EN
        .in_sub(in_sub),
`endif
        .out_valid(out_valid0), .out_ready(out_ready), .out_sum(out_sum0), .busy(busy0)
    );

    seq_wide_adder #(.WIDTH(32), .CHUNK(8), .ALGORITHM(1)) u_cla (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in0(in0), .in1(in1), .cin(cin),
`ifdef SEQ_WIDE_ADDER_SUB_EN
        .in_sub(in_sub),
`endif
        .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1), .busy(busy1)
    );

    seq_wide_adder #(.WIDTH(8), .CHUNK(8), .ALGORITHM(1)) u_one (
        .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in0(n_in0), .in1(n_in1), .cin(n_cin),
`ifdef SEQ_WIDE_ADDER_SUB_EN
        .in_sub(n_in_sub),
`endif
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_sum(n_out_sum), .busy(n_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for both 32-bit instances to raise out_valid; returns edges waited.
    task automatic wait_done(output int n);
        n = 0;
        while (!(out_valid0 && out_valid1) && n < 20) begin
            tick();
            n++;
        end
    endtask

    // Issues one op from IDLE, checks latency and result on both instances, then takes the result.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic s, input logic [32:0] exp, input string tag);
        int n;
        in0 = a; in1 = b; cin = c; in_sub = s; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, {62'd0, busy0, busy1}, 64'h3);
        wait_done(n);
        chk({tag, "_latency"}, 64'(n), 64'd4);
        chk({tag, "_sum_rca"}, 64'(out_sum0), 64'(exp));
        chk({tag, "_sum_cla"}, 64'(out_sum1), 64'(exp));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle"}, {61'd0, out_valid0, out_valid1, in_ready0 & in_ready1}, 64'h1);
    endtask

    initial begin
        int n;
        int seen;
        logic [32:0] held;

        rst = 1'b1; in_valid = 1'b0; in0 = '0; in1 = '0; cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
        n_in_valid = 1'b0; n_in0 = '0; n_in1 = '0; n_cin = 1'b0; n_in_sub = 1'b0; n_out_ready = 1'b0;
        tick();
        tick();
        chk("reset_out_valid", {62'd0, out_valid0, out_valid1}, 64'h0);
        chk("reset_busy", {62'd0, busy0, busy1}, 64'h0);
        chk("reset_sum", 64'(out_sum0 | out_sum1), 64'h0);
        rst = 1'b0;
        tick();
        chk("post_reset_in_ready", {62'd0, in_ready0, in_ready1}, 64'h3);

        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 33'h0_0000_0100, "t1_ff_plus_1");
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 33'h1_0000_0000, "t2_full_carry");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 33'h1_FFFF_FFFF, "max_operands");
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 33'h0_ACF1_3568, "mixed");

        // Hold the result under backpressure while the input side tries to inject a new op.
        in0 = 32'h8000_0000; in1 = 32'h8000_0000; cin = 1'b0; in_valid = 1'b1;
        tick();
        in0 = 32'h0000_0001; in1 = 32'h0000_0001; cin = 1'b1;
        wait_done(n);
        chk("t3_latency", 64'(n), 64'd4);
        held = out_sum0;
        chk("t3_sum", 64'(held), 64'h1_0000_0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_sum", {31'd0, out_sum0}, {31'd0, held});
            chk("t3_hold_flags", {60'd0, out_valid0, out_valid1, in_ready0, in_ready1}, 64'hC);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3_back_idle", {61'd0, out_valid0, busy0, in_ready0}, 64'h1);

        // Back-to-back ops with in_valid held; operand changes after accept must be ignored.
        in0 = 32'd1; in1 = 32'd2; cin = 1'b0; in_valid = 1'b1;
        tick();
        in0 = 32'd3; in1 = 32'd4;
        wait_done(n);
        chk("t4_first_sum", 64'(out_sum0), 64'd3);
        chk("t4_first_sum_cla", 64'(out_sum1), 64'd3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_gap_idle", {62'd0, in_ready0, busy0}, 64'h2);
        tick();
        in_valid = 1'b0;
        chk("t4_second_accept", {62'd0, busy0, in_ready0}, 64'h2);
        wait_done(n);
        chk("t4_second_latency", 64'(n), 64'd4);
        chk("t4_second_sum", 64'(out_sum0), 64'd7);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of RUN drops the op.
        in0 = 32'h0000_00FF; in1 = 32'h0000_00FF; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t5_async_clear", {61'd0, out_valid0, busy0, in_ready0}, 64'h1);
        tick();
        rst = 1'b0;
        tick();
        chk("t5_in_ready", {62'd0, in_ready0, in_ready1}, 64'h3);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid0 || out_valid1) seen++;
        end
        chk("t5_no_result", 64'(seen), 64'd0);
        chk("t5_sum_cleared", 64'(out_sum0), 64'h0);

`ifdef SEQ_WIDE_ADDER_SUB_EN
        run_op(32'd5, 32'd7, 1'b0, 1'b1, 33'h0_FFFF_FFFE, "t6_sub_borrow");
        run_op(32'd7, 32'd5, 1'b0, 1'b1, 33'h1_0000_0002, "t6_sub_no_borrow");
        run_op(32'd7, 32'd5, 1'b1, 1'b1, 33'h1_0000_0001, "t6_sub_with_cin");
`endif

        // Single-chunk instance: one RUN cycle then DONE.
        n_in0 = 8'hFF; n_in1 = 8'h01; n_cin = 1'b1; n_in_valid = 1'b1;
        tick();
        n_in_valid = 1'b0;
        n = 0;
        while (!n_out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("one_chunk_latency", 64'(n), 64'd1);
        chk("one_chunk_sum", 64'(n_out_sum), 64'h101);
        n_out_ready = 1'b1;
        tick();
        n_out_ready = 1'b0;
        chk("one_chunk_idle", {62'd0, n_out_valid, n_in_ready}, 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
